// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall
// handling and a saturating bubble counter for performance monitoring.
module id_ex_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             RegWrite_i,
    input  logic             MemReg_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic             ALUSrc_i,
    input  logic             Branch_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [9:0]       funct_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             RegWrite_o,
    output logic             MemReg_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             ALUSrc_o,
    output logic             Branch_o,
    output logic [1:0]       ALUOp_o,
    output logic [9:0]       funct_o,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    output logic [4:0]       rd_addr_o,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [XLEN-1:0]  pc_o,
    output logic             hazard_stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Everything EX needs from decode; an all-zero payload is a NoOp bubble.
    typedef struct packed {
        logic            reg_write;
        logic            mem_reg;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic [1:0]      alu_op;
        logic [9:0]      funct;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } ex_pl_t;

    ex_pl_t           id_pl;
    ex_pl_t           ex_d;
    ex_pl_t           ex_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             hazard;

    // Gather the decode-side inputs into one payload.
    assign id_pl = '{
        reg_write: RegWrite_i,
        mem_reg:   MemReg_i,
        mem_read:  MemRead_i,
        mem_write: MemWrite_i,
        alu_src:   ALUSrc_i,
        branch:    Branch_i,
        alu_op:    ALUOp_i,
        funct:     funct_i,
        rs1_addr:  rs1_addr_i,
        rs2_addr:  rs2_addr_i,
        rd_addr:   rd_addr_i,
        rs1_data:  rs1_data_i,
        rs2_data:  rs2_data_i,
        imm:       imm_i,
        pc:        pc_i
    };

    // Load-use detect; rs2 is compared for every opcode (conservative), and
    // a flush already squashes the consumer so no stall is requested then.
    always_comb begin
        hazard = 1'b0;
        if (!flush_i && ex_q.mem_read && (ex_q.rd_addr != 5'd0) &&
            ((ex_q.rd_addr == rs1_addr_i) || (ex_q.rd_addr == rs2_addr_i))) begin
            hazard = 1'b1;
        end
    end

    assign hazard_stall_o = hazard;

    // Next-state: hold on stall, bubble on flush/hazard, otherwise capture.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (!stall_i) begin
            if (flush_i || hazard) begin
                ex_d = '0;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                ex_d = id_pl;
            end
        end
    end

    // Pipeline and counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign RegWrite_o   = ex_q.reg_write;
    assign MemReg_o     = ex_q.mem_reg;
    assign MemRead_o    = ex_q.mem_read;
    assign MemWrite_o   = ex_q.mem_write;
    assign ALUSrc_o     = ex_q.alu_src;
    assign Branch_o     = ex_q.branch;
    assign ALUOp_o      = ex_q.alu_op;
    assign funct_o      = ex_q.funct;
    assign rs1_addr_o   = ex_q.rs1_addr;
    assign rs2_addr_o   = ex_q.rs2_addr;
    assign rd_addr_o    = ex_q.rd_addr;
    assign rs1_data_o   = ex_q.rs1_data;
    assign rs2_data_o   = ex_q.rs2_data;
    assign imm_o        = ex_q.imm;
    assign pc_o         = ex_q.pc;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage (counter narrowed to 4 bits so that
// saturation is reachable).
module tb_id_ex_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = 4'hF;

    typedef struct packed {
        logic            reg_write;
        logic            mem_reg;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic            branch;
        logic [1:0]      alu_op;
        logic [9:0]      funct;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } pl_t;

    typedef struct packed {
        pl_t              pl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;
    pl_t  in_pl;
    pl_t  out_pl;
    logic hazard_stall;
    logic [CNT_W-1:0] bubble_cnt;

    logic RegWrite_o, MemReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o;
    logic [1:0]      ALUOp_o;
    logic [9:0]      funct_o;
    logic [4:0]      rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [XLEN-1:0] rs1_data_o, rs2_data_o, imm_o, pc_o;

    pl_t              exp_pl;
    logic [CNT_W-1:0] exp_cnt;
    exp_t             sb_q[$];
    int               n_checks;
    int               n_errors;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .stall_i        (stall),
        .flush_i        (flush),
        .RegWrite_i     (in_pl.reg_write),
        .MemReg_i       (in_pl.mem_reg),
        .MemRead_i      (in_pl.mem_read),
        .MemWrite_i     (in_pl.mem_write),
        .ALUSrc_i       (in_pl.alu_src),
        .Branch_i       (in_pl.branch),
        .ALUOp_i        (in_pl.alu_op),
        .funct_i        (in_pl.funct),
        .rs1_addr_i     (in_pl.rs1_addr),
        .rs2_addr_i     (in_pl.rs2_addr),
        .rd_addr_i      (in_pl.rd_addr),
        .rs1_data_i     (in_pl.rs1_data),
        .rs2_data_i     (in_pl.rs2_data),
        .imm_i          (in_pl.imm),
        .pc_i           (in_pl.pc),
        .RegWrite_o     (RegWrite_o),
        .MemReg_o       (MemReg_o),
        .MemRead_o      (MemRead_o),
        .MemWrite_o     (MemWrite_o),
        .ALUSrc_o       (ALUSrc_o),
        .Branch_o       (Branch_o),
        .ALUOp_o        (ALUOp_o),
        .funct_o        (funct_o),
        .rs1_addr_o     (rs1_addr_o),
        .rs2_addr_o     (rs2_addr_o),
        .rd_addr_o      (rd_addr_o),
        .rs1_data_o     (rs1_data_o),
        .rs2_data_o     (rs2_data_o),
        .imm_o          (imm_o),
        .pc_o           (pc_o),
        .hazard_stall_o (hazard_stall),
        .bubble_cnt_o   (bubble_cnt)
    );

    assign out_pl = {RegWrite_o, MemReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o,
                     ALUOp_o, funct_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
                     rs1_data_o, rs2_data_o, imm_o, pc_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pl_t rand_pl();
        pl_t p;
        p.reg_write = 1'($urandom);
        p.mem_reg   = 1'($urandom);
        p.mem_read  = 1'($urandom);
        p.mem_write = 1'($urandom);
        p.alu_src   = 1'($urandom);
        p.branch    = 1'($urandom);
        p.alu_op    = 2'($urandom);
        p.funct     = 10'($urandom);
        p.rs1_addr  = 5'($urandom_range(0, 3));
        p.rs2_addr  = 5'($urandom_range(0, 3));
        p.rd_addr   = 5'($urandom_range(0, 3));
        p.rs1_data  = $urandom;
        p.rs2_data  = $urandom;
        p.imm       = $urandom;
        p.pc        = $urandom;
        return p;
    endfunction

    // Check hazard request, advance the model, push, clock, pop and compare.
    task automatic step();
        logic hz;
        exp_t e;
        #1;
        hz = !flush && exp_pl.mem_read && (exp_pl.rd_addr != 5'd0) &&
             ((exp_pl.rd_addr == in_pl.rs1_addr) || (exp_pl.rd_addr == in_pl.rs2_addr));
        check_eq("hazard_stall", 192'(hazard_stall), 192'(hz));
        if (!stall) begin
            if (flush || hz) begin
                exp_pl = '0;
                if (exp_cnt != CMAX) exp_cnt = exp_cnt + 4'd1;
            end else begin
                exp_pl = in_pl;
            end
        end
        e.pl  = exp_pl;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("ex_bundle", 192'(out_pl), 192'(e.pl));
        check_eq("bubble_cnt", 192'(bubble_cnt), 192'(e.cnt));
    endtask

    // Asynchronous reset away from the clock edge, then one zero capture.
    task automatic mid_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("reset_bundle", 192'(out_pl), 192'(0));
        check_eq("reset_cnt", 192'(bubble_cnt), 192'(0));
        check_eq("reset_hazard", 192'(hazard_stall), 192'(0));
        #1;
        rst_n   = 1'b1;
        exp_pl  = '0;
        exp_cnt = '0;
        sb_q.delete();
        in_pl   = '0;
        stall   = 1'b0;
        flush   = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        in_pl    = '0;
        exp_pl   = '0;
        exp_cnt  = '0;
        #12;
        check_eq("por_bundle", 192'(out_pl), 192'(0));
        check_eq("por_cnt", 192'(bubble_cnt), 192'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type capture
        in_pl = '0;
        in_pl.reg_write = 1'b1;
        in_pl.alu_op    = 2'b10;
        in_pl.rd_addr   = 5'd5;
        in_pl.rs1_data  = 32'h10;
        in_pl.funct     = 10'h020;
        step();
        check_eq("RegWrite_o", 192'(RegWrite_o), 192'(1));
        check_eq("ALUOp_o", 192'(ALUOp_o), 192'(2'b10));
        check_eq("rd_addr_o", 192'(rd_addr_o), 192'(5));
        check_eq("rs1_data_o", 192'(rs1_data_o), 192'(32'h10));

        mid_reset();

        // Load-use: one bubble, then the re-presented consumer is captured
        in_pl = '0;
        in_pl.mem_read = 1'b1;
        in_pl.mem_reg  = 1'b1;
        in_pl.rd_addr  = 5'd7;
        in_pl.rs1_addr = 5'd2;
        step();
        in_pl = '0;
        in_pl.reg_write = 1'b1;
        in_pl.rs1_addr  = 5'd7;
        in_pl.rd_addr   = 5'd8;
        in_pl.pc        = 32'h100;
        #1;
        check_eq("lu_hazard", 192'(hazard_stall), 192'(1));
        step();
        check_eq("lu_bubble_cnt", 192'(bubble_cnt), 192'(1));
        check_eq("lu_bubble_ctl", 192'(RegWrite_o), 192'(0));
        step();
        check_eq("lu_capture_pc", 192'(pc_o), 192'(32'h100));
        check_eq("lu_clear", 192'(hazard_stall), 192'(0));

        // x0 destination never stalls
        in_pl = '0;
        in_pl.mem_read = 1'b1;
        in_pl.rd_addr  = 5'd0;
        step();
        in_pl = '0;
        in_pl.reg_write = 1'b1;
        in_pl.rs2_addr  = 5'd0;
        in_pl.rd_addr   = 5'd3;
        step();
        check_eq("x0_cnt", 192'(bubble_cnt), 192'(1));
        check_eq("x0_capture_rd", 192'(rd_addr_o), 192'(3));

        // Flush of a store
        in_pl = rand_pl();
        in_pl.mem_write = 1'b1;
        flush = 1'b1;
        step();
        check_eq("flush_memwrite", 192'(MemWrite_o), 192'(0));
        check_eq("flush_cnt", 192'(bubble_cnt), 192'(2));
        flush = 1'b0;

        // Flush together with a load-use: single increment, no stall request
        in_pl = '0;
        in_pl.mem_read = 1'b1;
        in_pl.rd_addr  = 5'd9;
        step();
        in_pl = '0;
        in_pl.rs1_addr = 5'd9;
        in_pl.rd_addr  = 5'd4;
        flush = 1'b1;
        step();
        check_eq("flush_lu_cnt", 192'(bubble_cnt), 192'(3));
        flush = 1'b0;
        step();

        // Stall dominates flush and freezes everything
        in_pl = rand_pl();
        step();
        stall = 1'b1;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pl = rand_pl();
            step();
        end
        stall = 1'b0;
        step();
        check_eq("stall_release_cnt", 192'(bubble_cnt), 192'(4));
        flush = 1'b0;

        // Random mix with frequent hazards
        for (int i = 0; i < 60; i++) begin
            in_pl = rand_pl();
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 6) == 0);
            step();
        end
        stall = 1'b0;
        flush = 1'b0;

        // Saturation from a clean counter
        mid_reset();
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_pl = rand_pl();
            step();
        end
        check_eq("sat_cnt", 192'(bubble_cnt), 192'(15));
        step();
        check_eq("sat_hold", 192'(bubble_cnt), 192'(15));
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
